add4_seq_accum: RTL

Sequential accumulation controller wrapped around the team's 4-bit ripple-carry full adder. It accepts a burst of 4-bit operands over a valid/ready handshake and, each accepted beat, drives the running accumulator and the new operand onto the adder's A/B inputs. It registers the adder's 4-bit sum and carry-out, counting carries into an extended high part. At end of burst it presents the widened total downstream under a second valid/ready handshake. The adder instance sits outside this block; this block is its direct upstream driver and downstream consumer.

---
 rtl/add4_seq_accum.sv | 109 ++++++++++
 1 files changed

// File: rtl/add4_seq_accum.sv
// rtl/add4_seq_accum.sv - burst accumulator that drives and consumes an external 4-bit adder
module add4_seq_accum #(
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [3:0]         adder_a,
    output logic [3:0]         adder_b,
    input  logic [3:0]         adder_s,
    input  logic               adder_co,
    output logic [CNT_W+3:0]   out_sum,
    output logic [CNT_W-1:0]   out_beats,
    output logic               out_ovf,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       acc;
    logic [CNT_W-1:0] carry_cnt;
    logic [CNT_W-1:0] beats;
    logic             ovf;
    logic             beat_fire;
    logic             out_fire;

    assign in_ready  = (state != S_DONE);
    assign out_valid = (state == S_DONE);
    assign beat_fire = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // B is forced to zero while holding a result so the adder sees a quiet operand
    assign adder_a = acc;
    assign adder_b = (state == S_DONE) ? 4'b0000 : in_data;

    assign out_sum   = {carry_cnt, acc};
    assign out_beats = beats;
    assign out_ovf   = ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (beat_fire) begin
                    state_nxt = in_last ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (beat_fire && in_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_fire) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Result registers clear on the output handshake so the next burst starts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= 4'b0000;
            carry_cnt <= CNT_ZERO;
            beats     <= CNT_ZERO;
            ovf       <= 1'b0;
        end else if (out_fire) begin
            acc       <= 4'b0000;
            carry_cnt <= CNT_ZERO;
            beats     <= CNT_ZERO;
            ovf       <= 1'b0;
        end else if (beat_fire) begin
            acc <= adder_s;
            if (adder_co) begin
                carry_cnt <= carry_cnt + CNT_ONE;
                if (&carry_cnt) begin
                    ovf <= 1'b1;
                end
            end
            if (!(&beats)) begin
                beats <= beats + CNT_ONE;
            end
        end
    end

endmodule
